key_reader: RTL and testbench

Debounced pushbutton reader for the board's active-low KEY inputs. It turns raw, bouncing button levels into clean level outputs and single-cycle press/release events, with optional hold-to-repeat. Its event outputs drive the digit counter and display logic directly, replacing raw KEY/SW sampling. The top level wires KEY[0] to `RESET_N` and KEY[3:1] to `KEY_N`.

---
 rtl/key_reader.sv | 131 +++++++++++++
 tb/tb_key_reader.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/key_reader.sv
// Debounced reader for active-low pushbuttons: two-flop synchronizer, stable-count
// debounce and a per-key RELEASED/HOLD/REPEAT FSM producing press, release and repeat pulses.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   S_RELEASED | debounced level released, no timer activity
//   HOLD       | held, timing the initial delay to the first repeat pulse
//   REPEAT     | held, emitting a repeat pulse every REPEAT_PERIOD cycles
module key_reader #(
  parameter int N_KEYS          = 3,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic [N_KEYS-1:0] KEY_N,
  input  logic              REPEAT_EN,
  output logic [N_KEYS-1:0] PRESSED,
  output logic [N_KEYS-1:0] PRESS_PULSE,
  output logic [N_KEYS-1:0] RELEASE_PULSE
);

  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW   = $clog2(RMAX + 1);

  // Counters fire one count early so the flip/pulse lands on the edge they would reach the limit.
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] RD_LAST = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RP_LAST = TW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    S_RELEASED = 2'd0,
    S_HOLD     = 2'd1,
    S_REPEAT   = 2'd2
  } state_t;

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    state_t        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;
    logic          held_q, held_d;
    logic          sample_pressed;
    logic          went_down, went_up;

    always_ff @(posedge CLOCK_50) begin
      if (!RESET_N) begin
        sync1_q  <= 1'b1;
        sync2_q  <= 1'b1;
        stable_q <= 1'b0;
        db_cnt_q <= '0;
        state_q  <= S_RELEASED;
        tmr_q    <= '0;
        press_q  <= 1'b0;
        rel_q    <= 1'b0;
        held_q   <= 1'b0;
      end else begin
        sync1_q  <= KEY_N[k];
        sync2_q  <= sync1_q;
        stable_q <= stable_d;
        db_cnt_q <= db_cnt_d;
        state_q  <= state_d;
        tmr_q    <= tmr_d;
        press_q  <= press_d;
        rel_q    <= rel_d;
        held_q   <= held_d;
      end
    end

    assign sample_pressed = ~sync2_q;

    always_comb begin
      stable_d = stable_q;
      db_cnt_d = '0;
      if (sample_pressed != stable_q) begin
        if (db_cnt_q == DB_LAST) stable_d = ~stable_q;
        else                     db_cnt_d = db_cnt_q + 1'b1;
      end
    end

    assign went_down = stable_d & ~stable_q;
    assign went_up   = ~stable_d & stable_q;

    // Release is checked before timer expiry so it wins a same-cycle collision.
    always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      case (state_q)
        S_RELEASED: begin
          if (went_down) begin
            state_d = S_HOLD;
            press_d = 1'b1;
            tmr_d   = '0;
          end
        end
        S_HOLD, S_REPEAT: begin
          if (went_up) begin
            state_d = S_RELEASED;
            rel_d   = 1'b1;
            tmr_d   = '0;
          end else if (!REPEAT_EN) begin
            tmr_d = '0;
          end else if (tmr_q == ((state_q == S_HOLD) ? RD_LAST : RP_LAST)) begin
            state_d = S_REPEAT;
            press_d = 1'b1;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        default: begin
          state_d = S_RELEASED;
          tmr_d   = '0;
        end
      endcase
      held_d = (state_d != S_RELEASED);
    end

    assign PRESSED[k]       = held_q;
    assign PRESS_PULSE[k]   = press_q;
    assign RELEASE_PULSE[k] = rel_q;
  end

endmodule

// File: tb/tb_key_reader.sv
// Scoreboard bench for key_reader: a raw-history reference model queues the expected
// outputs for every edge and a monitor compares them against the DUT just after the edge.
module tb_key_reader;

  localparam int NK   = 3;
  localparam int DB   = 4;
  localparam int RD   = 10;
  localparam int RP   = 3;
  localparam int HMAX = 4096;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          en     = 1'b0;
  logic [NK-1:0] key_n  = '1;
  logic [NK-1:0] pressed, pp, rp;

  key_reader #(
    .N_KEYS(NK), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .CLOCK_50(clk), .RESET_N(rst_n), .KEY_N(key_n), .REPEAT_EN(en),
    .PRESSED(pressed), .PRESS_PULSE(pp), .RELEASE_PULSE(rp)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [NK-1:0] pressed;
    logic [NK-1:0] pp;
    logic [NK-1:0] rp;
  } exp_t;

  exp_t exp_q[$];
  exp_t mx;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 8;

  // Model state: raw level seen at each edge (1 = released), debounced level, repeat anchor.
  logic hist [NK][HMAX];
  logic m_stable [NK];
  int   m_anchor [NK];
  int   m_nrep [NK];

  task automatic chk(input string nm, input int c, input logic [31:0] got, input logic [31:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, c, got, expv);
    end
  endtask

  // A key's debounced level flips at edge c when the synchronized samples of the last DB
  // edges (raw levels from edges c-1-DB .. c-2) all disagree with it.
  task automatic model_step(input logic r, input logic e, input logic [NK-1:0] raw);
    exp_t x;
    logic flip;
    x.cyc = cyc; x.pressed = '0; x.pp = '0; x.rp = '0;
    for (int k = 0; k < NK; k++) begin
      if (!r) begin
        hist[k][cyc]   = 1'b1;
        hist[k][cyc-1] = 1'b1;
        m_stable[k]    = 1'b0;
        m_anchor[k]    = cyc;
        m_nrep[k]      = 0;
      end else begin
        hist[k][cyc] = raw[k];
        flip = 1'b1;
        for (int j = cyc - 1 - DB; j <= cyc - 2; j++)
          if ((hist[k][j] == 1'b0) == m_stable[k]) flip = 1'b0;
        if (flip && !m_stable[k]) begin
          m_stable[k] = 1'b1;
          x.pp[k]     = 1'b1;
          m_anchor[k] = cyc;
          m_nrep[k]   = 0;
        end else if (flip) begin
          m_stable[k] = 1'b0;
          x.rp[k]     = 1'b1;
        end else if (m_stable[k]) begin
          if (!e) m_anchor[k] = cyc;
          else if (cyc - m_anchor[k] == ((m_nrep[k] == 0) ? RD : RP)) begin
            x.pp[k]     = 1'b1;
            m_anchor[k] = cyc;
            m_nrep[k]++;
          end
        end
      end
      x.pressed[k] = m_stable[k];
    end
    exp_q.push_back(x);
  endtask

  task automatic drive(input logic r, input logic e, input logic [NK-1:0] kn);
    @(negedge clk);
    rst_n = r; en = e; key_n = kn;
    model_step(r, e, kn);
    cyc++;
  endtask

  task automatic hold(input int n, input logic e, input logic [NK-1:0] kn);
    for (int i = 0; i < n; i++) drive(1'b1, e, kn);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mx = exp_q.pop_front();
      chk("pressed",       mx.cyc, 32'(pressed), 32'(mx.pressed));
      chk("press_pulse",   mx.cyc, 32'(pp),      32'(mx.pp));
      chk("release_pulse", mx.cyc, 32'(rp),      32'(mx.rp));
      chk("pulse_overlap", mx.cyc, 32'(pp & rp), 32'd0);
    end
  end

  logic [NK-1:0] r_kn;
  logic          r_en;
  int            runlen [NK];
  int            rst_left;

  initial begin
    for (int k = 0; k < NK; k++) begin
      for (int j = 0; j < HMAX; j++) hist[k][j] = 1'b1;
      m_stable[k] = 1'b0; m_anchor[k] = 0; m_nrep[k] = 0; runlen[k] = 0;
    end

    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, '1);

    // clean press and release on key 0
    hold(12, 1'b0, 3'b110);
    hold(10, 1'b0, 3'b111);

    // bounce on key 1, then settle low
    for (int i = 0; i < 12; i++) drive(1'b1, 1'b0, ((i / 2) % 2 == 0) ? 3'b101 : 3'b111);
    hold(12, 1'b0, 3'b101);
    hold(10, 1'b0, 3'b111);

    // auto-repeat on key 2: pulses t, t+10, t+13, t+16, t+19, release at t+20
    hold(20, 1'b1, 3'b011);
    hold(12, 1'b1, 3'b111);

    // release lands on the same edge as the t+16 repeat
    hold(16, 1'b1, 3'b110);
    hold(10, 1'b1, 3'b111);

    // reset while in REPEAT with the key still held
    hold(20, 1'b1, 3'b110);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 3'b110);
    hold(15, 1'b1, 3'b110);
    hold(10, 1'b1, 3'b111);

    // parallel press on keys 0 and 2
    hold(10, 1'b0, 3'b010);
    hold(10, 1'b0, 3'b111);

    // randomized phase: glitches, long holds, enable toggles, occasional reset
    r_kn = '1; r_en = 1'b0; rst_left = 0;
    for (int i = 0; i < 1500; i++) begin
      for (int k = 0; k < NK; k++) begin
        if (runlen[k] == 0) begin
          r_kn[k]   = ~r_kn[k];
          runlen[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4))
                                                  : int'($urandom_range(5, 40));
        end else begin
          runlen[k]--;
        end
      end
      if ($urandom_range(0, 59) == 0) r_en = ~r_en;
      if (rst_left == 0 && $urandom_range(0, 399) == 0) rst_left = $urandom_range(1, 3);
      drive((rst_left == 0), r_en, r_kn);
      if (rst_left > 0) rst_left--;
    end

    @(posedge clk);
    #3;
    chk("scoreboard_drained", cyc, 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
